// File: rtl/pulse_train_generator.sv
// pulse_train_generator: programmable square-wave / pulse-train source.
// Produces a registered, glitch-free signal with a configurable period and
// high time. It runs continuously or for a burst of N periods. New
// configuration captured during a run takes effect only at a period boundary.
module pulse_train_generator #(
  parameter int CNT_WIDTH   = 24,
  parameter int BURST_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CNT_WIDTH-1:0]   cfg_period,
  input  logic [CNT_WIDTH-1:0]   cfg_high,
  input  logic                   cfg_load,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic                   start,
  input  logic                   stop,
  output logic                   sig_out,
  output logic                   busy,
  output logic                   done,
  output logic [BURST_WIDTH-1:0] edge_count
);

  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]   CNT_TWO   = CNT_WIDTH'(2);
  localparam logic [BURST_WIDTH-1:0] BURST_ONE = BURST_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // A period shorter than two clocks cannot have both a high and a low phase.
  function automatic logic [CNT_WIDTH-1:0] clamp_period(input logic [CNT_WIDTH-1:0] p);
    return (p < CNT_TWO) ? CNT_TWO : p;
  endfunction

  // The high time must leave at least one low cycle in the already-clamped period.
  function automatic logic [CNT_WIDTH-1:0] clamp_high(input logic [CNT_WIDTH-1:0] h,
                                                       input logic [CNT_WIDTH-1:0] p);
    logic [CNT_WIDTH-1:0] r;
    if (h == '0)     r = CNT_ONE;
    else if (h >= p) r = p - CNT_ONE;
    else             r = h;
    return r;
  endfunction

  state_t                 state_q;
  state_t                 state_d;
  logic                   boundary;
  logic                   run_end;

  logic [CNT_WIDTH-1:0]   act_period;
  logic [CNT_WIDTH-1:0]   act_high;
  logic [CNT_WIDTH-1:0]   shd_period;
  logic [CNT_WIDTH-1:0]   shd_high;
  logic                   pend;
  logic                   stop_flag;

  logic [CNT_WIDTH-1:0]   phase_cnt;
  logic [BURST_WIDTH-1:0] burst_rem;
  logic                   burst_mode;

  logic [CNT_WIDTH-1:0]   ld_period;
  logic [CNT_WIDTH-1:0]   ld_high;
  logic [CNT_WIDTH-1:0]   eff_high;
  logic [CNT_WIDTH-1:0]   start_high;
  logic                   phase_zero;
  logic                   burst_last;

  // Clamped load values and the high time the next period will use.
  always_comb begin
    ld_period  = clamp_period(cfg_period);
    ld_high    = clamp_high(cfg_high, ld_period);
    eff_high   = pend ? shd_high : act_high;
    start_high = cfg_load ? ld_high : eff_high;
    phase_zero = (phase_cnt == '0);
    burst_last = burst_mode && (burst_rem == BURST_ONE);
  end

  // Next-state logic; a period boundary is the last LOW cycle.
  always_comb begin
    state_d  = state_q;
    boundary = 1'b0;
    run_end  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = HIGH;
      end
      HIGH: begin
        if (phase_zero) state_d = LOW;
      end
      LOW: begin
        if (phase_zero) begin
          boundary = 1'b1;
          // A stop arriving on the boundary cycle still belongs to this period.
          if (stop_flag || stop || burst_last) begin
            state_d = IDLE;
            run_end = 1'b1;
          end else begin
            state_d = HIGH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      stop_flag  <= 1'b0;
      sig_out    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      edge_count <= '0;
    end else begin
      state_q <= state_d;
      sig_out <= (state_d == HIGH);
      busy    <= (state_d != IDLE);
      done    <= run_end;
      if (state_d == IDLE)
        stop_flag <= 1'b0;
      else if ((state_q != IDLE) && stop)
        stop_flag <= 1'b1;
      if ((state_q == IDLE) && start)
        edge_count <= BURST_ONE;
      else if (boundary && !run_end)
        edge_count <= edge_count + BURST_ONE;
    end
  end

  // Active/shadow configuration: direct writes when idle, deferred while running.
  always_ff @(posedge clock) begin
    if (reset) begin
      act_period <= CNT_TWO;
      act_high   <= CNT_ONE;
      shd_period <= CNT_TWO;
      shd_high   <= CNT_ONE;
      pend       <= 1'b0;
    end else if (state_q == IDLE) begin
      if (cfg_load) begin
        act_period <= ld_period;
        act_high   <= ld_high;
        shd_period <= ld_period;
        shd_high   <= ld_high;
      end else if (pend) begin
        // A load that coincided with the final boundary of a run lands here.
        act_period <= shd_period;
        act_high   <= shd_high;
      end
      pend <= 1'b0;
    end else begin
      if (boundary && pend) begin
        act_period <= shd_period;
        act_high   <= shd_high;
      end
      if (cfg_load) begin
        shd_period <= ld_period;
        shd_high   <= ld_high;
        pend       <= 1'b1;
      end else if (boundary) begin
        pend <= 1'b0;
      end
    end
  end

  // Phase down-counter and burst bookkeeping; only meaningful while running.
  always_ff @(posedge clock) begin
    case (state_q)
      IDLE: begin
        if (start) begin
          phase_cnt  <= start_high - CNT_ONE;
          burst_rem  <= burst_len;
          burst_mode <= (burst_len != '0);
        end
      end
      HIGH: begin
        if (phase_zero) phase_cnt <= act_period - act_high - CNT_ONE;
        else            phase_cnt <= phase_cnt - CNT_ONE;
      end
      LOW: begin
        if (phase_zero) begin
          phase_cnt <= eff_high - CNT_ONE;
          if (burst_mode) burst_rem <= burst_rem - BURST_ONE;
        end else begin
          phase_cnt <= phase_cnt - CNT_ONE;
        end
      end
      default: phase_cnt <= phase_cnt;
    endcase
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench for pulse_train_generator. The expected waveform of
// each run is built as a queue of per-cycle sig_out levels from the period,
// high time and period count; busy, done and edge_count follow from it.
module tb_pulse_train_generator;

  logic        clock;
  logic        reset;
  logic [23:0] cfg_period;
  logic [23:0] cfg_high;
  logic        cfg_load;
  logic [15:0] burst_len;
  logic        start;
  logic        stop;
  logic        sig_out;
  logic        busy;
  logic        done;
  logic [15:0] edge_count;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];

  pulse_train_generator #(.CNT_WIDTH(24), .BURST_WIDTH(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_load   (cfg_load),
    .burst_len  (burst_len),
    .start      (start),
    .stop       (stop),
    .sig_out    (sig_out),
    .busy       (busy),
    .done       (done),
    .edge_count (edge_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp_p(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  function automatic int clamp_h(input int h, input int p);
    int r;
    r = (h < 1) ? 1 : h;
    if (r > p - 1) r = p - 1;
    return r;
  endfunction

  // Append 'count' periods of the clamped shape to the expected waveform.
  task automatic push_periods(input int p_raw, input int h_raw, input int count);
    int p;
    int h;
    p = clamp_p(p_raw);
    h = clamp_h(h_raw, p);
    for (int k = 0; k < count; k++)
      for (int j = 0; j < p; j++)
        exp_q.push_back(j < h);
  endtask

  task automatic load(input int p, input int h);
    cfg_period = 24'(p);
    cfg_high   = 24'(h);
    cfg_load   = 1'b1;
    tick();
    cfg_load   = 1'b0;
  endtask

  // Start a run and compare every cycle against exp_q, then the two cycles after it.
  // Strobes are applied after the sample with the given index (-1 = never).
  task automatic run_wave(input int load_at, input int lp, input int lh,
                          input int stop_at, input int busy_start_at,
                          input bit stop_with_start);
    int  n_end;
    int  edges;
    bit  e_sig;
    n_end = exp_q.size();
    edges = 0;
    start = 1'b1;
    stop  = stop_with_start;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i <= n_end + 1; i++) begin
      if (i < n_end) begin
        e_sig = exp_q[i];
        if (e_sig && (i == 0 || !exp_q[i-1])) edges++;
        check("sig_out", 32'(sig_out), 32'(e_sig));
        check("busy", 32'(busy), 32'd1);
        check("done", 32'(done), 32'd0);
      end else begin
        check("sig_out_idle", 32'(sig_out), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("done_end", 32'(done), 32'(i == n_end));
      end
      check("edge_count", 32'(edge_count), 32'(edges[15:0]));
      start      = (i == busy_start_at);
      stop       = (i == stop_at);
      cfg_load   = (i == load_at);
      cfg_period = 24'(lp);
      cfg_high   = 24'(lh);
      if (i <= n_end) tick();
    end
    start    = 1'b0;
    stop     = 1'b0;
    cfg_load = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int p, h, n, s, hold;
    reset      = 1'b1;
    cfg_period = '0;
    cfg_high   = '0;
    cfg_load   = 1'b0;
    burst_len  = '0;
    start      = 1'b0;
    stop       = 1'b0;
    tick();
    tick();
    check("rst_sig", 32'(sig_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_edges", 32'(edge_count), 32'd0);
    reset = 1'b0;
    tick();

    // Basic 10/3 continuous, stopped during the 5th period.
    load(10, 3);
    burst_len = 16'd0;
    push_periods(10, 3, 5);
    run_wave(-1, 0, 0, 45, -1, 1'b0);

    // Burst of 3 at 4/2; edge_count holds afterwards.
    load(4, 2);
    burst_len = 16'd3;
    push_periods(4, 2, 3);
    run_wave(-1, 0, 0, -1, -1, 1'b0);
    tick();
    tick();
    check("edge_hold", 32'(edge_count), 32'd3);
    check("done_quiet", 32'(done), 32'd0);

    // Clamping cases.
    load(1, 5);
    burst_len = 16'd2;
    push_periods(1, 5, 2);
    run_wave(-1, 0, 0, -1, -1, 1'b0);
    load(6, 0);
    burst_len = 16'd1;
    push_periods(6, 0, 1);
    run_wave(-1, 0, 0, -1, -1, 1'b0);
    load(6, 9);
    push_periods(6, 9, 1);
    run_wave(-1, 0, 0, -1, -1, 1'b0);

    // Reload during a HIGH phase: current period keeps 4/4, then 1/3.
    load(8, 4);
    burst_len = 16'd3;
    push_periods(8, 4, 1);
    push_periods(4, 1, 2);
    run_wave(1, 4, 1, -1, -1, 1'b0);

    // Load on the boundary cycle: applies one period later.
    load(4, 2);
    burst_len = 16'd3;
    push_periods(4, 2, 2);
    push_periods(6, 3, 1);
    run_wave(3, 6, 3, -1, -1, 1'b0);

    // Stop mid-HIGH with a start while busy.
    load(6, 3);
    burst_len = 16'd0;
    push_periods(6, 3, 1);
    run_wave(-1, 0, 0, 1, 2, 1'b0);

    // Start and stop together while idle: the run proceeds.
    burst_len = 16'd2;
    push_periods(6, 3, 2);
    run_wave(-1, 0, 0, -1, -1, 1'b1);

    // Randomized bursts and stopped continuous runs.
    for (int r = 0; r < 6; r++) begin
      p = int'($urandom_range(0, 12));
      h = int'($urandom_range(0, 14));
      load(p, h);
      if (r % 2 == 0) begin
        n = int'($urandom_range(1, 4));
        burst_len = 16'(n);
        push_periods(p, h, n);
        run_wave(-1, 0, 0, -1, -1, 1'b0);
      end else begin
        burst_len = 16'd0;
        s = int'($urandom_range(0, 3 * clamp_p(p) - 1));
        push_periods(p, h, s / clamp_p(p) + 1);
        run_wave(-1, 0, 0, s, -1, 1'b0);
      end
      tick();
    end

    // Reset during HIGH of a 5-period burst.
    load(7, 4);
    burst_len = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_sig", 32'(sig_out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_edges", 32'(edge_count), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    hold = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) hold++;
    end
    check("mid_rst_no_done", 32'(hold), 32'd0);
    burst_len = 16'd2;
    push_periods(2, 1, 2);
    run_wave(-1, 0, 0, -1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_train_generator.md
Name: pulse_train_generator

Overview:
- Programmable square-wave/pulse-train source. It is the transmit-side counterpart of the frequency meter's input conditioning path.
- Generates a registered, glitch-free digital signal with a given period and high time, either continuously or as a burst of N periods.
- Used as an on-chip stimulus source for self-test of the frequency meter, and as an exportable test-signal output.

Parameters:
- CNT_WIDTH, 24, width of period/high-time counters and configuration inputs (in clock cycles).
- BURST_WIDTH, 16, width of burst length and edge counter.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cfg_period  input  CNT_WIDTH  period in clock cycles
- cfg_high  input  CNT_WIDTH  high time in clock cycles
- cfg_load  input  1  1-cycle strobe; captures cfg_period/cfg_high into shadow registers
- burst_len  input  BURST_WIDTH  number of periods per run; 0 = continuous
- start  input  1  1-cycle strobe; starts a run when idle
- stop  input  1  1-cycle strobe; ends the run at the end of the current period
- sig_out  output  1  generated signal, registered
- busy  output  1  high while in HIGH or LOW state
- done  output  1  1-cycle pulse when a run ends
- edge_count  output  BURST_WIDTH  rising edges produced since the last start; wraps

Behaviour:
- Reset (reset=1 at a rising clock edge):
  - State is IDLE; sig_out=0, busy=0, done=0, edge_count=0.
  - Active and shadow period/high registers are set to 2 and 1.
  - The pending-update flag and the stop-request flag are cleared.
- Reset asserted mid-run aborts immediately; done is not pulsed.
- Clamping applies at capture, on cfg_load:
  - period < 2 is stored as 2.
  - high = 0 is stored as 1.
  - high >= stored period is stored as stored period - 1.
- Capture:
  - In IDLE, cfg_load writes the shadow and active registers directly.
  - In HIGH/LOW, cfg_load writes the shadow registers and sets the pending flag.
  - Pending values are copied to active only at a period boundary, so the current period is never distorted.
  - Several loads within one period: the last one wins.
- FSM states are IDLE, HIGH and LOW. One down-counter, phase_cnt, is used.
  - IDLE:
    - start=1 → HIGH; phase_cnt=active_high-1.
    - burst_len is latched into burst_rem.
    - edge_count is set to 1; sig_out=1 on the next cycle (1-cycle latency from start).
    - stop in IDLE is ignored.
  - HIGH: sig_out=1. When phase_cnt=0 → LOW, phase_cnt=active_period-active_high-1; otherwise decrement.
  - LOW: sig_out=0. When phase_cnt=0 the period boundary occurs:
    - Apply the pending update, if any.
    - If burst mode is active, decrement burst_rem.
    - If the stop flag is set, or burst_rem reaches 0 in burst mode → IDLE with done=1 for one cycle.
    - Otherwise → HIGH with the new active values, and edge_count increments.
- Resulting waveform: sig_out is high for exactly active_high cycles and low for active_period-active_high cycles. The period is active_period clocks.
- stop is latched into the stop flag when asserted in HIGH or LOW. The flag is cleared on entry to IDLE.
- Strobes are prioritised as follows:
  - start while busy is ignored.
  - start and stop in the same cycle while IDLE: start wins and stop is ignored.
  - cfg_load in the same cycle as a period boundary is treated as pending for the next boundary.
- busy=1 exactly while the state is HIGH or LOW.
- done is asserted in the cycle IDLE is entered; at that edge sig_out is already 0.
- edge_count wraps modulo 2^BURST_WIDTH. It holds its value in IDLE until the next start.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Basic period/duty: load period=10, high=3 while idle, start, burst_len=0.
  - sig_out rises 1 cycle after start.
  - Pattern repeats 3 high / 7 low for 5 periods; busy=1 throughout; edge_count=5 after the 5th rise.
- Burst: period=4, high=2, burst_len=3, start.
  - Exactly 3 rising edges; done pulses once, 12 cycles after sig_out first rises.
  - busy falls with done; edge_count=3 and holds.
- Clamping: load period=1, high=5 → active period 2, high 1.
  - Output toggles 1,0,1,0.
  - Load period=6, high=0 → high 1; load period=6, high=9 → high 5.
- Glitch-free reload: running at period=8, high=4; load period=4, high=1 during a HIGH phase.
  - Current period completes as 4/4; the following periods are 1/3; no short pulse is generated.
- Stop and strobe conflicts:
  - Continuous run at period=6, high=3; stop mid-HIGH → that period completes (3 high, 3 low), then done pulses and the FSM enters IDLE.
  - start while busy has no effect.
  - start and stop in the same idle cycle → run begins.
- Reset mid-run: assert reset during HIGH with burst_len=5.
  - Next cycle sig_out=0, busy=0, edge_count=0, and done is never pulsed.
  - Active config returns to 2/1.
